// File: rtl/serial_parity_rx_pkg.sv
// Shared definitions for the parity-protected byte link receivers.
//   rx_state_e : receive FSM state encoding (2 bits)
//   PAR_EVEN / PAR_ODD : parity-mode selector values for parity_check
package serial_parity_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/serial_parity_rx_parity_check.sv
// Combinational parity checker for one received frame.
//   data     in  DATA_W  received data bits
//   par_bit  in  1       received parity bit
//   odd_mode in  1       PAR_EVEN: XOR of data+parity must be 0; PAR_ODD: must be 1
//   err      out 1       1 when the parity relation does not hold
module parity_check
  import serial_parity_rx_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] data,
  input  logic              par_bit,
  input  logic              odd_mode,
  output logic              err
);

  // XOR over data and parity is 0 for a good even frame and 1 for a good odd
  // frame, so folding in the mode bit leaves 1 only on an error.
  assign err = (^{data, par_bit}) ^ (odd_mode == PAR_ODD);

endmodule

// File: rtl/serial_parity_rx.sv
// Receiver for the parity-protected byte link.
// Deserialises start/data(LSB first)/parity/stop frames from a bit-strobed
// line, checks parity and framing, and offers each byte through a one-entry
// valid/ready buffer. Errors and overruns feed a saturating counter.
//   clk        in   1       rising-edge clock
//   rst        in   1       asynchronous active-high reset
//   bit_valid  in   1       serial_in carries a new line bit this cycle
//   serial_in  in   1       line bit, idle level 1
//   out_data   out  DATA_W  received byte, held while out_valid
//   out_perr   out  1       parity error for out_data
//   out_ferr   out  1       framing error (stop bit 0) for out_data
//   out_valid  out  1       buffer holds a frame
//   out_ready  in   1       consumer accepts when out_valid & out_ready
//   overrun    out  1       one-cycle pulse: frame completed while buffer full
//   err_count  out  CNT_W   saturating count of erroneous frames plus overruns
module serial_parity_rx
  import serial_parity_rx_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ODD_PAR = 0,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_valid,
  input  logic              serial_in,
  output logic [DATA_W-1:0] out_data,
  output logic              out_perr,
  output logic              out_ferr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  output logic [CNT_W-1:0]  err_count
);

  localparam int CB = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CB-1:0] CNT_LAST = CB'(DATA_W - 1);
  localparam logic [CB-1:0] CNT_ONE  = CB'(1);
  localparam logic          PAR_MODE = (ODD_PAR != 0) ? PAR_ODD : PAR_EVEN;

  // Adds 0..2 to the counter and clamps at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
    if (sum[CNT_W]) sat_add = {CNT_W{1'b1}};
    else            sat_add = sum[CNT_W-1:0];
  endfunction

  rx_state_e         state_q, state_d;
  logic [CB-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_perr_q, out_perr_d;
  logic              out_ferr_q, out_ferr_d;
  logic              out_valid_q, out_valid_d;
  logic              overrun_q, overrun_d;
  logic [CNT_W-1:0]  err_count_q, err_count_d;

  logic frame_done;
  logic perr;
  logic ferr;
  logic can_load;
  logic load;
  logic drop;
  logic [1:0] err_inc;

  parity_check #(
    .DATA_W (DATA_W)
  ) u_parity_check (
    .data     (shift_q),
    .par_bit  (par_q),
    .odd_mode (PAR_MODE),
    .err      (perr)
  );

  // Receive FSM: every transition is gated by the bit strobe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    if (bit_valid) begin
      unique case (state_q)
        IDLE: begin
          // No glitch filtering: any 0 seen while idle is a start bit.
          if (!serial_in) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          shift_d[cnt_q] = serial_in;
          if (cnt_q == CNT_LAST) state_d = PARITY;
          else                   cnt_d   = cnt_q + CNT_ONE;
        end
        PARITY: begin
          par_d   = serial_in;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign frame_done = bit_valid && (state_q == STOP);
  assign ferr       = ~serial_in;

  // A full buffer can still accept a new frame if it empties on this edge.
  assign can_load = !out_valid_q || out_ready;
  assign load     = frame_done && can_load;
  assign drop     = frame_done && !can_load;

  // An erroneous frame counts even when dropped, so a dropped bad frame adds 2.
  assign err_inc = {1'b0, frame_done && (perr || ferr)} + {1'b0, drop};

  always_comb begin
    out_data_d  = out_data_q;
    out_perr_d  = out_perr_q;
    out_ferr_d  = out_ferr_q;
    out_valid_d = out_valid_q;
    overrun_d   = drop;
    err_count_d = sat_add(err_count_q, err_inc);
    if (load) begin
      out_data_d  = shift_q;
      out_perr_d  = perr;
      out_ferr_d  = ferr;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      out_data_q  <= '0;
      out_perr_q  <= 1'b0;
      out_ferr_q  <= 1'b0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      out_data_q  <= out_data_d;
      out_perr_q  <= out_perr_d;
      out_ferr_q  <= out_ferr_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_perr  = out_perr_q;
  assign out_ferr  = out_ferr_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_serial_parity_rx.sv
module tb_serial_parity_rx;

  logic       clk;
  logic       rst;
  logic       bit_valid;
  logic       serial_in;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_perr;
  logic       out_ferr;
  logic       out_valid;
  logic       overrun;
  logic [7:0] err_count;

  logic [7:0] o_out_data;
  logic       o_out_perr;
  logic       o_out_ferr;
  logic       o_out_valid;
  logic       o_overrun;
  logic [7:0] o_err_count;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_err = 0;

  serial_parity_rx #(.DATA_W(8), .ODD_PAR(0), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bit_valid (bit_valid),
    .serial_in (serial_in),
    .out_data  (out_data),
    .out_perr  (out_perr),
    .out_ferr  (out_ferr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun),
    .err_count (err_count)
  );

  serial_parity_rx #(.DATA_W(8), .ODD_PAR(1), .CNT_W(8)) dut_odd (
    .clk       (clk),
    .rst       (rst),
    .bit_valid (bit_valid),
    .serial_in (serial_in),
    .out_data  (o_out_data),
    .out_perr  (o_out_perr),
    .out_ferr  (o_out_ferr),
    .out_valid (o_out_valid),
    .out_ready (out_ready),
    .overrun   (o_overrun),
    .err_count (o_err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One strobed line bit; returns 1ns after the edge that samples it.
  task automatic send_bit(input logic b);
    @(negedge clk);
    bit_valid = 1'b1;
    serial_in = b;
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
    serial_in = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Start bit, data LSB first, parity bit; stop bit is sent by the caller.
  task automatic send_head(input logic [7:0] d, input logic p);
    logic [7:0] v;
    v = d;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
    send_bit(p);
  endtask

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  initial begin
    rst       = 1'b1;
    bit_valid = 1'b0;
    serial_in = 1'b1;
    out_ready = 1'b0;
    idle(3);
    chk("rst_valid",   out_valid, 0);
    chk("rst_data",    out_data,  0);
    chk("rst_perr",    out_perr,  0);
    chk("rst_ferr",    out_ferr,  0);
    chk("rst_overrun", overrun,   0);
    chk("rst_errcnt",  err_count, 0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // 1: clean A5h, with idle gaps mid-frame
    out_ready = 1'b1;
    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    idle(2);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    idle(1);
    send_bit(1'b1);
    send_bit(1'b0);
    chk("t1_valid_before_stop", out_valid, 0);
    send_bit(1'b1);
    chk("t1_valid", out_valid, 1);
    chk("t1_data",  out_data,  8'hA5);
    chk("t1_perr",  out_perr,  0);
    chk("t1_ferr",  out_ferr,  0);
    chk("t1_errcnt", err_count, 0);
    chk("t1_odd_perr", o_out_perr, 1);
    idle(1);
    chk("t1_valid_after_xfer", out_valid, 0);

    // 2: A5h with wrong even parity
    send_head(8'hA5, 1'b1);
    send_bit(1'b1);
    exp_err = exp_err + 1;
    chk("t2_valid", out_valid, 1);
    chk("t2_data",  out_data,  8'hA5);
    chk("t2_perr",  out_perr,  1);
    chk("t2_ferr",  out_ferr,  0);
    chk("t2_errcnt", err_count, exp_err);
    chk("t2_odd_perr", o_out_perr, 0);
    chk("t2_odd_data", o_out_data, 8'hA5);
    idle(1);

    // 3: 3Ch with stop bit 0
    send_head(8'h3C, 1'b0);
    send_bit(1'b0);
    exp_err = exp_err + 1;
    chk("t3_valid", out_valid, 1);
    chk("t3_data",  out_data,  8'h3C);
    chk("t3_perr",  out_perr,  0);
    chk("t3_ferr",  out_ferr,  1);
    chk("t3_errcnt", err_count, exp_err);
    idle(1);

    // 4: overrun with consumer stalled
    out_ready = 1'b0;
    send_head(8'h11, 1'b0);
    send_bit(1'b1);
    chk("t4_valid1", out_valid, 1);
    chk("t4_data1",  out_data,  8'h11);
    chk("t4_ovr_none", overrun, 0);
    send_head(8'h22, 1'b0);
    chk("t4_ovr_before", overrun, 0);
    send_bit(1'b1);
    exp_err = exp_err + 1;
    chk("t4_ovr_pulse", overrun, 1);
    chk("t4_data_kept", out_data, 8'h11);
    chk("t4_errcnt", err_count, exp_err);
    idle(1);
    chk("t4_ovr_clear", overrun, 0);
    chk("t4_valid_held", out_valid, 1);
    chk("t4_data_held", out_data, 8'h11);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("t4_valid_after_xfer", out_valid, 0);

    // 5: transfer and load on the same edge
    out_ready = 1'b0;
    send_head(8'h0F, 1'b0);
    send_bit(1'b1);
    chk("t5_valid1", out_valid, 1);
    chk("t5_data1",  out_data,  8'h0F);
    send_head(8'h81, 1'b0);
    out_ready = 1'b1;
    send_bit(1'b1);
    chk("t5_valid2", out_valid, 1);
    chk("t5_data2",  out_data,  8'h81);
    chk("t5_no_ovr", overrun,   0);
    chk("t5_errcnt", err_count, exp_err);
    idle(1);
    chk("t5_valid_after_xfer", out_valid, 0);

    // 6: reset mid-frame, then clean frame, then saturation
    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid",  out_valid, 0);
    chk("t6_rst_data",   out_data,  0);
    chk("t6_rst_errcnt", err_count, 0);
    chk("t6_rst_ferr",   out_ferr,  0);
    exp_err = 0;
    idle(2);
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    send_head(8'h5A, 1'b0);
    send_bit(1'b1);
    chk("t6_valid", out_valid, 1);
    chk("t6_data",  out_data,  8'h5A);
    chk("t6_perr",  out_perr,  0);
    chk("t6_ferr",  out_ferr,  0);
    chk("t6_errcnt", err_count, 0);
    idle(1);

    out_ready = 1'b0;
    for (int f = 0; f < 128; f++) begin
      send_head(8'h5A, 1'b1);
      send_bit(1'b1);
      exp_err = sat(exp_err + ((f == 0) ? 1 : 2));
      if (f == 1) begin
        chk("t6_drop_bad_adds2", err_count, exp_err);
        chk("t6_drop_ovr", overrun, 1);
      end
    end
    chk("t6_errcnt_255", err_count, 255);
    send_head(8'h5A, 1'b1);
    send_bit(1'b1);
    exp_err = sat(exp_err + 2);
    chk("t6_errcnt_sat", err_count, exp_err);
    chk("t6_data_kept", out_data, 8'h5A);
    chk("t6_perr_kept", out_perr, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
